// File: rtl/renode_ahb_arbiter.sv
// renode_ahb_arbiter: two-manager AHB-Lite arbiter onto one subordinate, one transfer at a time.
// Optional RENODE_AHB_ARBITER_ROUND_ROBIN_EN selects round-robin instead of fixed manager-0 priority.
`default_nettype none

module renode_ahb_arbiter #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic [AddressWidth-1:0] m0_haddr,
  input  logic [1:0]              m0_htrans,
  input  logic                    m0_hwrite,
  input  logic [2:0]              m0_hsize,
  input  logic [DataWidth-1:0]    m0_hwdata,
  output logic                    m0_hready,
  output logic [DataWidth-1:0]    m0_hrdata,
  output logic                    m0_hresp,
  input  logic [AddressWidth-1:0] m1_haddr,
  input  logic [1:0]              m1_htrans,
  input  logic                    m1_hwrite,
  input  logic [2:0]              m1_hsize,
  input  logic [DataWidth-1:0]    m1_hwdata,
  output logic                    m1_hready,
  output logic [DataWidth-1:0]    m1_hrdata,
  output logic                    m1_hresp,
  output logic [AddressWidth-1:0] s_haddr,
  output logic [1:0]              s_htrans,
  output logic                    s_hwrite,
  output logic [2:0]              s_hsize,
  output logic [DataWidth-1:0]    s_hwdata,
  output logic                    s_hready,
  input  logic                    s_hreadyout,
  input  logic [DataWidth-1:0]    s_hrdata,
  input  logic                    s_hresp
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_grant;
  logic                    r_last_grant;
  logic                    w_grant_nxt;
  logic [1:0]              r_pend_valid;
  logic [AddressWidth-1:0] r_pend_addr  [2];
  logic                    r_pend_write [2];
  logic [2:0]              r_pend_size  [2];
  logic [DataWidth-1:0]    r_hrdata     [2];

  logic [AddressWidth-1:0] w_haddr  [2];
  logic [1:0]              w_htrans [2];
  logic                    w_hwrite [2];
  logic [2:0]              w_hsize  [2];
  logic [1:0]              w_hready;
  logic [1:0]              w_accept;
  logic                    w_done;

  assign w_haddr[0]  = m0_haddr;
  assign w_haddr[1]  = m1_haddr;
  assign w_htrans[0] = m0_htrans;
  assign w_htrans[1] = m1_htrans;
  assign w_hwrite[0] = m0_hwrite;
  assign w_hwrite[1] = m1_hwrite;
  assign w_hsize[0]  = m0_hsize;
  assign w_hsize[1]  = m1_hsize;

  assign w_done = (r_state == ST_DATA) && s_hreadyout;

  // Only NONSEQ/SEQ are latched; SEQ is re-issued downstream as NONSEQ.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_hready[i] = !r_pend_valid[i] || (w_done && (r_grant == 1'(i)));
      w_accept[i] = w_hready[i] && ((w_htrans[i] == 2'b10) || (w_htrans[i] == 2'b11));
    end
  end

  always_comb begin
    w_grant_nxt = r_grant;
    if (r_pend_valid == 2'b11) begin
`ifdef RENODE_AHB_ARBITER_ROUND_ROBIN_EN
      w_grant_nxt = ~r_last_grant;
`else
      w_grant_nxt = 1'b0;
`endif
    end else if (r_pend_valid[1]) begin
      w_grant_nxt = 1'b1;
    end else if (r_pend_valid[0]) begin
      w_grant_nxt = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_htrans    = 2'b00;
    s_haddr     = '0;
    s_hwrite    = 1'b0;
    s_hsize     = 3'b000;
    s_hwdata    = '0;
    case (r_state)
      ST_IDLE: begin
        if (|r_pend_valid) w_state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        s_htrans = 2'b10;
        s_haddr  = r_pend_addr[r_grant];
        s_hwrite = r_pend_write[r_grant];
        s_hsize  = r_pend_size[r_grant];
        if (s_hreadyout) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        s_hwdata = r_grant ? m1_hwdata : m0_hwdata;
        if (s_hreadyout) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign s_hready = s_hreadyout;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && (|r_pend_valid)) r_grant <= w_grant_nxt;
      if (w_done) r_last_grant <= r_grant;
    end
  end

  // A new request on the completion edge takes priority over clearing the slot.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_pend_valid <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_pend_addr[i]  <= '0;
        r_pend_write[i] <= 1'b0;
        r_pend_size[i]  <= 3'b000;
        r_hrdata[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_accept[i]) begin
          r_pend_valid[i] <= 1'b1;
          r_pend_addr[i]  <= w_haddr[i];
          r_pend_write[i] <= w_hwrite[i];
          r_pend_size[i]  <= w_hsize[i];
        end else if (w_done && (r_grant == 1'(i))) begin
          r_pend_valid[i] <= 1'b0;
        end
        if (w_done && (r_grant == 1'(i))) r_hrdata[i] <= s_hrdata;
      end
    end
  end

  assign m0_hready = w_hready[0];
  assign m1_hready = w_hready[1];
  assign m0_hrdata = (w_done && !r_grant) ? s_hrdata : r_hrdata[0];
  assign m1_hrdata = (w_done &&  r_grant) ? s_hrdata : r_hrdata[1];
  assign m0_hresp  = (w_done && !r_grant) ? s_hresp  : 1'b0;
  assign m1_hresp  = (w_done &&  r_grant) ? s_hresp  : 1'b0;

endmodule

`default_nettype wire

// File: doc/renode_ahb_arbiter.md
RENODE_AHB_ARBITER -- requirements
Module: renode_ahb_arbiter

Interface
REQ-001 SHALL have parameter AddressWidth, default 32, width of all haddr ports.
REQ-002 SHALL have parameter DataWidth, default 32, width of all hwdata/hrdata ports.
REQ-003 SHALL have port hclk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port hresetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have, for each manager i in {0,1}: mi_haddr in AddressWidth, mi_htrans in 2, mi_hwrite in 1, mi_hsize in 3, mi_hwdata in DataWidth.
REQ-006 SHALL have, for each manager i: mi_hready out 1 (transfer done/accept), mi_hrdata out DataWidth, mi_hresp out 1.
REQ-007 SHALL have subordinate-side outputs s_haddr AddressWidth, s_htrans 2, s_hwrite 1, s_hsize 3, s_hwdata DataWidth, s_hready 1.
REQ-008 SHALL have subordinate-side inputs s_hreadyout 1, s_hrdata DataWidth, s_hresp 1.

Function
REQ-009 Manager i address phase SHALL be accepted at a rising edge where mi_hready=1 and mi_htrans is NONSEQ(2) or SEQ(3); haddr/hwrite/hsize latched into pending_i, pending_i valid set.
REQ-010 IDLE(0) and BUSY(1) on mi_htrans SHALL never be latched; SEQ SHALL be forwarded as NONSEQ.
REQ-011 mi_hready SHALL equal !pending_valid_i OR (state==DATA AND grant==i AND s_hreadyout).
REQ-012 FSM states IDLE, ADDR, DATA; IDLE->ADDR at edge when any pending_valid, grant registered at that edge; IDLE holds otherwise.
REQ-013 In ADDR: s_htrans=NONSEQ, s_haddr/s_hwrite/s_hsize from pending_grant; ADDR->DATA at edge where s_hreadyout=1, else hold.
REQ-014 In DATA: s_htrans=IDLE, s_hwdata=m(grant)_hwdata; DATA->IDLE at edge where s_hreadyout=1, clearing pending_valid_grant and updating last_grant=grant.
REQ-015 In all states s_hready SHALL equal s_hreadyout; in IDLE s_htrans=IDLE and s_haddr=0.
REQ-016 m(grant)_hrdata SHALL equal s_hrdata and m(grant)_hresp equal s_hresp in the DATA completion cycle; otherwise hrdata holds last value, hresp=OKAY(0).
REQ-017 If the completing manager issues a new NONSEQ on the completion edge, set of pending_valid SHALL win over clear.
REQ-018 Address and data phases on the subordinate side SHALL never overlap; minimum latency from acceptance edge to subordinate address sample = 2 edges.
REQ-019 A non-granted manager's pending request SHALL be preserved unchanged until granted.

Reset
REQ-020 On hresetn=0, asynchronously: state=IDLE, pending_valid_0/1=0, grant=0, last_grant=1, mi_hrdata=0.
REQ-021 During/after reset outputs SHALL be: mi_hready=1, mi_hresp=0, s_htrans=IDLE, s_haddr=0, s_hwdata=0.
REQ-022 Reset asserted mid-transfer SHALL abandon the transfer with no completion signalled to either manager.

Configuration
REQ-023 Macro RENODE_AHB_ARBITER_ROUND_ROBIN_EN defined: when both pending in IDLE, grant SHALL go to the manager != last_grant.
REQ-024 Macro undefined: when both pending, manager 0 SHALL always win (fixed priority); single pending always granted.

Verification
REQ-025 Single read: m0 NONSEQ addr 'h1000, s_hreadyout=1 constant, s_hrdata='hCAFE0001 -> s_htrans NONSEQ 2 edges later, m0_hready high one cycle with m0_hrdata='hCAFE0001.
REQ-026 Write with wait states: m1 write 'h2000 data 'hA5A5A5A5, s_hreadyout low 3 cycles in DATA -> s_hwdata='hA5A5A5A5 held, m1_hready low until completion.
REQ-027 Simultaneous requests after reset, 3 rounds each: round-robin -> grants 0,1,0,1,0,1; without macro -> 0,0,0,1,1,1 when m0 keeps requesting back-to-back.
REQ-028 Back-to-back: m0 issues new NONSEQ on its completion edge -> pending_valid_0 stays 1, next transfer issued, no lost request.
REQ-029 Reset mid DATA (hresetn low 1 cycle) -> state IDLE, m0/m1_hready=1, s_htrans=IDLE immediately, no stale completion afterward.
REQ-030 BUSY/IDLE on m0_htrans for 5 cycles -> s_htrans stays IDLE, m0_hready stays 1.
